// File: rtl/mem_burst_master_if.sv
// Command, write-data, read-data and memory-port bundle for mem_burst_master.
// The master modport is the burst engine; the slave modport is the requester/memory side.
interface mem_burst_master_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;

    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;

    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    logic [ADDR_W-1:0] Direccion;
    logic [DATA_W-1:0] Dato;
    logic              WE;
    logic [DATA_W-1:0] Q4;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_data, wr_valid, rd_ready, Q4,
        output cmd_ready, wr_ready, rd_data, rd_valid,
        output Direccion, Dato, WE
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_data, wr_valid, rd_ready, Q4,
        input  cmd_ready, wr_ready, rd_data, rd_valid,
        input  Direccion, Dato, WE
    );
endinterface

// File: rtl/mem_burst_master.sv
// Burst master moving 1..2^ADDR_W beats between streams and a combinational-read memory.
// Define BURST_CHECKSUM_EN to add a running checksum output over all transferred beats.
module mem_burst_master #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_burst_master_if.master bus,
    output logic               done,
    output logic               busy
`ifdef BURST_CHECKSUM_EN
   ,output logic [DATA_W-1:0]  checksum
`endif
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              we_raw;
    logic              rd_load;
    logic              beat;
    logic [DATA_W-1:0] beat_data;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = rd_valid_q;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        we_raw        = 1'b0;
        rd_load       = 1'b0;

        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    rem_d   = bus.cmd_len;
                    state_d = bus.cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                bus.wr_ready = 1'b1;
                we_raw       = bus.wr_valid;
                if (bus.wr_valid) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == '0) state_d = DONE;
                end
            end
            READ: begin
                // Refill the output register whenever it is empty or being drained.
                rd_load = !rd_valid_q || bus.rd_ready;
                if (rd_load) begin
                    rd_data_d  = bus.Q4;
                    rd_valid_d = 1'b1;
                    addr_d     = addr_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                    if (rem_q == '0) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_valid_q && bus.rd_ready) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.rd_ready && !rd_load) rd_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Reset kills the memory write strobe immediately, even mid-burst.
    assign bus.WE        = we_raw & ~rst;
    assign bus.Direccion = addr_q;
    assign bus.Dato      = bus.wr_data;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign done          = (state_q == DONE);
    assign busy          = (state_q != IDLE);

    assign beat      = we_raw | rd_load;
    assign beat_data = (state_q == WRITE) ? bus.wr_data : bus.Q4;

`ifdef BURST_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && bus.cmd_valid) csum_d = '0;
        else if (beat)                        csum_d = csum_q + beat_data;
    end

    always_ff @(posedge clk) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    logic unused_beat;
    assign unused_beat = beat ^ (^beat_data);
`endif
endmodule

// File: doc/mem_burst_master.md
MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, memory address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 32, memory word width.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port cmd_valid, input, 1, command request.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted this cycle when both are high.
REQ-007 SHALL have port cmd_write, input, 1: 1 = write burst, 0 = read burst.
REQ-008 SHALL have port cmd_addr, input, ADDR_W, burst base address.
REQ-009 SHALL have port cmd_len, input, ADDR_W: beats minus one (1..32 beats).
REQ-010 SHALL have port wr_data/wr_valid/wr_ready, in/in/out, DATA_W/1/1, write-data stream.
REQ-011 SHALL have port rd_data/rd_valid/rd_ready, out/out/in, DATA_W/1/1, read-data stream.
REQ-012 SHALL have port Direccion/Dato/WE, out/out/out, ADDR_W/DATA_W/1, memory address, write data and write enable.
REQ-013 SHALL have port Q4, input, DATA_W, combinational memory read data for the current Direccion.
REQ-014 SHALL have port done, output, 1, one-cycle pulse at burst completion.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, WRITE, READ, DRAIN, DONE.
REQ-017 SHALL assert cmd_ready only in IDLE; on accept, latch addr=cmd_addr, remaining=cmd_len, and go to WRITE or READ per cmd_write.
REQ-018 SHALL, in WRITE, drive wr_ready=1, Direccion=addr, Dato=wr_data, WE=wr_valid (combinational); WE SHALL be 0 in every other state.
REQ-019 SHALL, for each WRITE beat (wr_valid high), increment addr modulo 2^ADDR_W (31 wraps to 0), decrement remaining, and go to DONE after the beat where remaining==0.
REQ-020 SHALL hold Direccion=addr in READ and load rd_data<=Q4, rd_valid<=1 when (!rd_valid || rd_ready), advancing addr/remaining as in REQ-019.
REQ-021 SHALL clear rd_valid when rd_ready is high and no new beat loads the same cycle.
REQ-022 SHALL go READ->DRAIN after loading the last beat, and DRAIN->DONE when the held beat is consumed (rd_valid && rd_ready).
REQ-023 SHALL make the first read beat visible on rd_valid exactly 2 cycles after the command-accept edge, and sustain 1 beat/cycle while rd_ready stays high.
REQ-024 SHALL pulse done for exactly one cycle in DONE and return to IDLE on the next edge; no command is accepted in DONE.
REQ-025 SHALL ignore wr_valid outside WRITE, and ignore cmd_valid while busy.

Reset
REQ-026 SHALL, on a rising edge of clk with rst high, force IDLE with rd_valid=0, done=0, addr=0, remaining=0 and rd_data=0.
REQ-027 SHALL gate WE to 0 combinationally whenever rst is high, including reset asserted mid-burst; an aborted burst SHALL produce no done pulse.

Configuration
REQ-028 SHALL, with BURST_CHECKSUM_EN defined, provide output checksum (DATA_W): cleared on command accept and updated by checksum <= checksum + beat_data (mod 2^DATA_W) per transferred write or read-load beat, stable from DONE until the next accept.
REQ-029 SHALL, without BURST_CHECKSUM_EN, omit the checksum port and its logic entirely.

Verification
REQ-030 SHALL cover: write addr=4 len=3, data 0xA,0xB,0xC,0xD on consecutive cycles -> WE high 4 cycles at Direccion 4,5,6,7; done one cycle later.
REQ-031 SHALL cover: read addr=30 len=3 with memory preloaded [30]=7,[31]=8,[0]=1,[1]=2 -> rd_data 7,8,1,2 (wrap), first valid 2 cycles after accept.
REQ-032 SHALL cover: read len=2 with rd_ready held low 3 cycles after first valid -> rd_data stays at the first beat, no beat lost or duplicated, Direccion frozen.
REQ-033 SHALL cover: write burst with wr_valid toggled 1,0,1,0,1 for len=2 -> WE high only on valid cycles, 3 beats written, done after the third beat.
REQ-034 SHALL cover: rst asserted on the second beat of a len=7 write -> WE=0 in that cycle, IDLE next cycle, no done, untouched addresses unchanged.
REQ-035 SHALL cover: with BURST_CHECKSUM_EN, writing 1,2,3,0xFFFFFFFF -> checksum=0x00000005.
